mux_logic_unit: RTL
===================

Name: mux_logic_unit

Overview:
- Parametrised, registered bitwise logic unit. Every per-bit operation is built from mux_2x1 cells, with the select driven by the A-operand bit.
- Two modes:
  - MAP: one result per input beat.
  - FOLD: chains the operation across a framed stream, using an accumulator, and emits one result per frame.
- Sits between a valid/ready producer and consumer in the datapath.
- Successor to the fixed 1-bit gate set: adds width, op select, pipelining, handshake and framing.

Parameters:
- WIDTH, 8, operand/result width in bits.
- CNT_W, 8, width of the beat counter; saturates at 2^CNT_W-1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mode  in  1  0=MAP, 1=FOLD; sampled on an accepted beat.
- op  in  3  operation select; sampled on every accepted beat.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_a  in  WIDTH  operand A; this is the mux select.
- in_b  in  WIDTH  operand B.
- in_last  in  1  marks the last beat of a frame.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer ready.
- out_y  out  WIDTH  result.
- out_last  out  1  end of frame (MAP: copy of in_last; FOLD: always 1).
- out_beats  out  CNT_W  number of beats that produced this result.

Behaviour:
- Reset: asynchronous, active-low. Clock is clk, reset is rst_n. While rst_n=0, and after release:
  - out_valid=0, out_y=0, out_last=0, out_beats=0.
  - acc=0, beat counter=0, state=IDLE.
  - in_ready=1.
- Op encoding, per bit, written as mux_2x1(d0,d1,sel=x):
  - 0 AND: (0,b)
  - 1 NAND: (1,~b)
  - 2 OR: (b,1)
  - 3 NOR: (~b,0)
  - 4 XOR: (b,~b)
  - 5 XNOR: (~b,b)
  - 6 PASS_A: (0,1)
  - 7 NOT_A: (1,0)
- Result r = op(x, in_b), where:
  - MAP: x = in_a.
  - FOLD, first beat of a frame: x = in_a.
  - FOLD, later beats: x = acc.
  - Consequence: a one-beat FOLD frame equals MAP.
- Handshake: in_ready = !out_valid || out_ready. It is purely combinational on the output state and never depends on in_valid or in_last.
- Output register: out_valid rises 1 cycle after a producing beat is accepted. out_y, out_last and out_beats hold stable while out_valid && !out_ready. Back-to-back throughput is 1 beat/cycle when out_ready=1.
- FSM states:
  - IDLE: no frame open.
  - FOLD: frame open, acc valid.
- FSM transitions:
  - IDLE, accepted beat with mode=0: result loads into the output register; out_beats=1; stay in IDLE.
  - IDLE, accepted beat with mode=1 and in_last=1: output r with out_beats=1; stay in IDLE.
  - IDLE, accepted beat with mode=1 and in_last=0: acc<=r, counter<=1, go to FOLD. Nothing is output.
  - FOLD, accepted beat with in_last=0: acc<=op(acc,in_b), counter++ (saturating).
  - FOLD, accepted beat with in_last=1: output op(acc,in_b) with out_beats=counter+1 (saturating) and out_last=1; go to IDLE.
- Mode lock: mode is latched on the first beat of a frame and ignored while in FOLD. op is per beat, so mixed ops within a frame are legal.
- Accepted means the acceptance condition holds. Non-producing beats also require in_ready, so the rule is uniform.
- Simultaneous events: when out_ready=1 and a new beat arrives in the same cycle as a held result, the old result retires and the new one loads in the same edge. No bubble.
- Saturation: the counter stays at 2^CNT_W-1 and never wraps.
- Reset mid-frame: the partial frame is discarded with no output; the next beat starts a new frame.

Decomposition:
- Package mux_logic_pkg contains:
  - op localparams: OP_AND=0 … OP_NOT_A=7.
  - MODE_MAP=0, MODE_FOLD=1.
  - State encoding: IDLE, FOLD.
- Sub-module mux_logic_slice (parameter WIDTH): a generate loop of WIDTH×mux_2x1 instances, fed by an 8-way d0/d1 selection on op. It is purely combinational and reuses the existing mux_2x1 cell unchanged.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> out_valid=0, out_y=0, out_beats=0, in_ready=1. Release -> values unchanged until the first beat.
- MAP sweep, WIDTH=8, a=8'hCA, b=8'hA5, ops 0..7 -> 80, 7F, EF, 10, 6F, 90, CA, 35, each with out_beats=1 and 1-cycle latency.
- FOLD XOR, 3 beats: a=8'h0F, b=01, 02, 04 (last on beat 3) -> a single out_valid with out_y=08, out_beats=3, out_last=1.
- Backpressure: out_ready=0 with a result held -> in_ready=0, out_y stable across 5 cycles, the next beat is not accepted. Raise out_ready -> the next result follows with no loss and no duplication.
- Saturation: CNT_W=4, 20-beat FOLD AND frame of all FF -> out_y=FF, out_beats=15.
- Reset mid-frame: 2 FOLD beats, then pulse rst_n=0 -> no output. Then one FOLD beat, AND a=FF b=3C last=1 -> out_y=3C, out_beats=1.

Source files
------------

// File: rtl/mux_logic_pkg.sv
// Shared op codes, mode values and FSM state type for the mux-based logic unit.
package mux_logic_pkg;

  localparam logic [2:0] OP_AND    = 3'd0;
  localparam logic [2:0] OP_NAND   = 3'd1;
  localparam logic [2:0] OP_OR     = 3'd2;
  localparam logic [2:0] OP_NOR    = 3'd3;
  localparam logic [2:0] OP_XOR    = 3'd4;
  localparam logic [2:0] OP_XNOR   = 3'd5;
  localparam logic [2:0] OP_PASS_A = 3'd6;
  localparam logic [2:0] OP_NOT_A  = 3'd7;

  localparam logic MODE_MAP  = 1'b0;
  localparam logic MODE_FOLD = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    FOLD = 1'b1
  } state_e;

endpackage

// File: rtl/mux_2x1.sv
// Basic 2:1 multiplexer cell: y = sel ? d1 : d0.
module mux_2x1 (
  input  logic d0,
  input  logic d1,
  input  logic sel,
  output logic y
);

  assign y = sel ? d1 : d0;

endmodule

// File: rtl/mux_logic_slice.sv
// Combinational WIDTH-bit logic op: each bit is a mux_2x1 whose select is the x operand bit.
module mux_logic_slice
  import mux_logic_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH-1:0] d0;
  logic [WIDTH-1:0] d1;

  // Data legs per op; x then picks d0 (x=0) or d1 (x=1) bit by bit.
  always_comb begin
    d0 = '0;
    d1 = '0;
    case (op)
      OP_AND:    begin d0 = '0;  d1 = b;  end
      OP_NAND:   begin d0 = '1;  d1 = ~b; end
      OP_OR:     begin d0 = b;   d1 = '1; end
      OP_NOR:    begin d0 = ~b;  d1 = '0; end
      OP_XOR:    begin d0 = b;   d1 = ~b; end
      OP_XNOR:   begin d0 = ~b;  d1 = b;  end
      OP_PASS_A: begin d0 = '0;  d1 = '1; end
      OP_NOT_A:  begin d0 = '1;  d1 = '0; end
      default:   begin d0 = '0;  d1 = '0; end
    endcase
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    mux_2x1 u_mux (
      .d0  (d0[gi]),
      .d1  (d1[gi]),
      .sel (x[gi]),
      .y   (y[gi])
    );
  end

endmodule

// File: rtl/mux_logic_unit.sv
// Registered mux-based logic unit with valid/ready handshake; MAP emits per beat,
// FOLD chains the op through an accumulator and emits one result per frame.
module mux_logic_unit
  import mux_logic_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic [2:0]       op,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_last,
  output logic [CNT_W-1:0] out_beats
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q;
  logic [WIDTH-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_y_q;
  logic             out_last_q;
  logic [CNT_W-1:0] out_beats_q;

  logic             accept;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] r;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Inside an open frame the accumulator replaces operand A as the mux select.
  assign x     = (state_q == FOLD) ? acc_q : in_a;
  assign cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  mux_logic_slice #(
    .WIDTH (WIDTH)
  ) u_slice (
    .op (op),
    .x  (x),
    .b  (in_b),
    .y  (r)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
      out_last_q  <= 1'b0;
      out_beats_q <= '0;
    end else begin
      // A held result retires here; a producing beat below overrides in the same edge.
      if (out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (accept) begin
        case (state_q)
          IDLE: begin
            if (mode == MODE_MAP || in_last) begin
              out_valid_q <= 1'b1;
              out_y_q     <= r;
              out_last_q  <= in_last;
              out_beats_q <= CNT_ONE;
            end else begin
              acc_q   <= r;
              cnt_q   <= CNT_ONE;
              state_q <= FOLD;
            end
          end
          FOLD: begin
            if (in_last) begin
              out_valid_q <= 1'b1;
              out_y_q     <= r;
              out_last_q  <= 1'b1;
              out_beats_q <= cnt_d;
              state_q     <= IDLE;
            end else begin
              acc_q <= r;
              cnt_q <= cnt_d;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_y     = out_y_q;
  assign out_last  = out_last_q;
  assign out_beats = out_beats_q;

endmodule
